// File: rtl/trap_collect.sv
// trap_collect
//   Upstream feeder for the exception unit. Carries decode-detected exception
//   flags and the PC through the DE and EM pipeline registers. Merges them
//   with memory-stage access faults and a synchronised external interrupt.
//   Emits one prioritised, registered, one-cycle trap report, then ignores
//   further events until the exception unit has finished its sequence.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   stall                  holds the DE/EM flag registers
//   flush_DE, flush_EM     clear the matching flag register (flush beats stall)
//   id_valid, id_pc        decode slot holds a real instruction, and its PC
//   id_illegal/ecall/mret  decode-detected conditions
//   mem_valid_in           memory-stage slot is not a bubble
//   mem_l_fault/s_fault    load/store access fault of the EM instruction
//   irq_async, mie         external interrupt (async level), mstatus.MIE
//   busy                   exception unit sequence active
//   illegal_inst, ecall_m, mret, l_access_fault, s_access_fault, interrupt
//                          registered one-hot report, high for one cycle
//   epc_cur, epc_next      PC of the reported instruction and PC+4
//   irq_pending            latched interrupt awaiting report

module trap_collect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_DE,
  input  logic        flush_EM,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_illegal,
  input  logic        id_ecall,
  input  logic        id_mret,
  input  logic        mem_valid_in,
  input  logic        mem_l_fault,
  input  logic        mem_s_fault,
  input  logic        irq_async,
  input  logic        mie,
  input  logic        busy,
  output logic        illegal_inst,
  output logic        ecall_m,
  output logic        mret,
  output logic        l_access_fault,
  output logic        s_access_fault,
  output logic        interrupt,
  output logic [31:0] epc_cur,
  output logic [31:0] epc_next,
  output logic        irq_pending
);

  // Bit positions inside the one-hot report vector.
  localparam int B_ILL  = 0;
  localparam int B_ECL  = 1;
  localparam int B_MRET = 2;
  localparam int B_LF   = 3;
  localparam int B_SF   = 4;
  localparam int B_INT  = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REPORT    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // DE / EM pipeline registers
  // ---------------------------------------------------------------------
  logic        de_valid_q, de_valid_d;
  logic [31:0] de_pc_q, de_pc_d;
  logic        de_ill_q, de_ill_d;
  logic        de_ecl_q, de_ecl_d;
  logic        de_mret_q, de_mret_d;

  logic        em_valid_q, em_valid_d;
  logic [31:0] em_pc_q, em_pc_d;
  logic        em_ill_q, em_ill_d;
  logic        em_ecl_q, em_ecl_d;
  logic        em_mret_q, em_mret_d;

  always_comb begin
    de_valid_d = de_valid_q;
    de_pc_d    = de_pc_q;
    de_ill_d   = de_ill_q;
    de_ecl_d   = de_ecl_q;
    de_mret_d  = de_mret_q;
    if (flush_DE) begin
      // PC is left as is; it is meaningless once valid is cleared.
      de_valid_d = 1'b0;
      de_ill_d   = 1'b0;
      de_ecl_d   = 1'b0;
      de_mret_d  = 1'b0;
    end else if (!stall) begin
      de_valid_d = id_valid;
      de_pc_d    = id_pc;
      de_ill_d   = id_illegal & id_valid;
      de_ecl_d   = id_ecall & id_valid;
      de_mret_d  = id_mret & id_valid;
    end
  end

  always_comb begin
    em_valid_d = em_valid_q;
    em_pc_d    = em_pc_q;
    em_ill_d   = em_ill_q;
    em_ecl_d   = em_ecl_q;
    em_mret_d  = em_mret_q;
    if (flush_EM) begin
      em_valid_d = 1'b0;
      em_ill_d   = 1'b0;
      em_ecl_d   = 1'b0;
      em_mret_d  = 1'b0;
    end else if (!stall) begin
      em_valid_d = de_valid_q;
      em_pc_d    = de_pc_q;
      em_ill_d   = de_ill_q;
      em_ecl_d   = de_ecl_q;
      em_mret_d  = de_mret_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_valid_q <= 1'b0;
      de_pc_q    <= '0;
      de_ill_q   <= 1'b0;
      de_ecl_q   <= 1'b0;
      de_mret_q  <= 1'b0;
      em_valid_q <= 1'b0;
      em_pc_q    <= '0;
      em_ill_q   <= 1'b0;
      em_ecl_q   <= 1'b0;
      em_mret_q  <= 1'b0;
    end else begin
      de_valid_q <= de_valid_d;
      de_pc_q    <= de_pc_d;
      de_ill_q   <= de_ill_d;
      de_ecl_q   <= de_ecl_d;
      de_mret_q  <= de_mret_d;
      em_valid_q <= em_valid_d;
      em_pc_q    <= em_pc_d;
      em_ill_q   <= em_ill_d;
      em_ecl_q   <= em_ecl_d;
      em_mret_q  <= em_mret_d;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt synchroniser, edge detector and pending latch
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   irq_pending_q, irq_pending_d;
  logic                   irq_rise;
  logic                   irq_clr;

  assign sync_d[0] = irq_async;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync_prev_d = sync_q[SYNC_STAGES-1];
  assign irq_rise    = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  // A new rising edge wins over a clear issued on the same edge.
  assign irq_pending_d = irq_rise | (irq_pending_q & ~irq_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      sync_prev_q   <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      sync_prev_q   <= sync_prev_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // ---------------------------------------------------------------------
  // Candidate selection: fixed priority, interrupt only on a clean slot
  // ---------------------------------------------------------------------
  logic       cand;
  logic [5:0] sel;

  always_comb begin
    sel  = '0;
    cand = em_valid_q & mem_valid_in;
    if (cand) begin
      if (em_ill_q)                  sel[B_ILL]  = 1'b1;
      else if (em_ecl_q)             sel[B_ECL]  = 1'b1;
      else if (mem_l_fault)          sel[B_LF]   = 1'b1;
      else if (mem_s_fault)          sel[B_SF]   = 1'b1;
      else if (em_mret_q)            sel[B_MRET] = 1'b1;
      else if (irq_pending_q && mie) sel[B_INT]  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Report FSM
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        wb_cnt_q, wb_cnt_d;
  logic [5:0]  flags_q, flags_d;
  logic [31:0] epc_cur_q, epc_cur_d;
  logic [31:0] epc_next_q, epc_next_d;

  always_comb begin
    state_d    = state_q;
    wb_cnt_d   = wb_cnt_q;
    flags_d    = '0;         // report is a single-cycle pulse
    epc_cur_d  = epc_cur_q;
    epc_next_d = epc_next_q;
    irq_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|sel) begin
          flags_d    = sel;
          epc_cur_d  = em_pc_q;
          epc_next_d = em_pc_q + 32'd4;
          irq_clr    = sel[B_INT];
          state_d    = REPORT;
        end
      end
      REPORT: begin
        wb_cnt_d = 1'b0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Give the exception unit two cycles to acknowledge with busy.
        if (busy)          state_d = WAIT_DONE;
        else if (wb_cnt_q) state_d = IDLE;
        else               wb_cnt_d = 1'b1;
      end
      WAIT_DONE: begin
        if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_cnt_q   <= 1'b0;
      flags_q    <= '0;
      epc_cur_q  <= 32'd0;
      epc_next_q <= 32'd4;
    end else begin
      state_q    <= state_d;
      wb_cnt_q   <= wb_cnt_d;
      flags_q    <= flags_d;
      epc_cur_q  <= epc_cur_d;
      epc_next_q <= epc_next_d;
    end
  end

  assign illegal_inst   = flags_q[B_ILL];
  assign ecall_m        = flags_q[B_ECL];
  assign mret           = flags_q[B_MRET];
  assign l_access_fault = flags_q[B_LF];
  assign s_access_fault = flags_q[B_SF];
  assign interrupt      = flags_q[B_INT];
  assign epc_cur        = epc_cur_q;
  assign epc_next       = epc_next_q;
  assign irq_pending    = irq_pending_q;

endmodule
